pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards and taken branches resolved in EX.
- Freezes the pipeline while data memory is not ready.
- Flags a sticky error on a memory timeout.
- Control outputs are combinational from the current FSM state and inputs; they drive the stall/flush pins of the pipeline register blocks.

---
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch, data-memory wait and timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic                  ex_mem_read,
   input  logic                  ex_branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_stall,
   output logic                  ifid_stall,
   output logic                  ifid_flush,
   output logic                  idex_stall,
   output logic                  idex_flush,
   output logic                  exmem_stall,
   output logic                  memwb_flush,
   output logic                  mem_timeout_err,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_events
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       load_use;
   logic       mem_block;

   assign load_use  = ex_mem_read && (ex_rd_addr != '0) &&
                      ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                       (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
   assign mem_block = mem_req && !mem_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no latches are inferred.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idex_stall   = 1'b0;
      idex_flush   = 1'b0;
      exmem_stall  = 1'b0;
      memwb_flush  = 1'b0;

      // RUN and MEM_WAIT decode identically: an unserved request freezes, anything else advances.
      if (!rst) begin
         if ((state == ERR) || mem_block) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
         end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
         end
      end

      case (state)
         RUN: begin
            if (mem_block) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready || !mem_req) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = ERR;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         ERR:     state_nxt = ERR;
         default: state_nxt = RUN;
      endcase
   end

   // The flag is the ERR state itself, so it holds through rst until the reset edge.
   assign mem_timeout_err = (state == ERR);

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else if (state != ERR) begin
         if (pc_stall)                 stall_cycles <= stall_cycles + 32'd1;
         if (ifid_flush || idex_flush) flush_events <= flush_events + 32'd1;
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

   localparam int AW      = 5;
   localparam int TIMEOUT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
   logic          mem_req, mem_ready;
   logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
   logic          exmem_stall, memwb_flush, mem_timeout_err;
   logic [31:0]   stall_cycles, flush_events;

   pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
      .memwb_flush(memwb_flush), .mem_timeout_err(mem_timeout_err),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   always #5 clk = ~clk;

   // ctrl order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush}
   localparam logic [6:0] C_NONE   = 7'b0000000;
   localparam logic [6:0] C_FREEZE = 7'b1101011;
   localparam logic [6:0] C_BRANCH = 7'b0010100;
   localparam logic [6:0] C_BUBBLE = 7'b1100100;

   typedef struct packed {
      logic [6:0]  ctrl;
      logic        err;
      logic [31:0] sc;
      logic [31:0] fe;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   // Behavioural model: consecutive unserved memory cycles, sticky error, event totals.
   int          m_pend = 0;
   bit          m_err  = 1'b0;
   logic [31:0] m_sc   = '0;
   logic [31:0] m_fe   = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic u1, input logic u2, input logic [AW-1:0] rd,
                       input logic ld, input logic br, input logic req, input logic rdy);
      exp_t e;
      bit   hazard, unserved;
      @(posedge clk);
      #1;
      rst = r; id_rs1_addr = rs1; id_rs2_addr = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
      ex_rd_addr = rd; ex_mem_read = ld; ex_branch_taken = br; mem_req = req; mem_ready = rdy;

      hazard   = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      unserved = req && !rdy;
      if (r)                       e.ctrl = C_NONE;
      else if (m_err || unserved)  e.ctrl = C_FREEZE;
      else if (br)                 e.ctrl = C_BRANCH;
      else if (hazard)             e.ctrl = C_BUBBLE;
      else                         e.ctrl = C_NONE;
      e.err = m_err;
`ifdef HAZARD_PERF_CNT_EN
      e.sc = m_sc;
      e.fe = m_fe;
`else
      e.sc = '0;
      e.fe = '0;
`endif
      sb.push_back(e);

      if (r) begin
         m_pend = 0; m_err = 1'b0; m_sc = '0; m_fe = '0;
      end else if (!m_err) begin
         m_sc = m_sc + 32'(e.ctrl[6]);
         m_fe = m_fe + 32'(e.ctrl[4] | e.ctrl[2]);
         if (unserved) begin
            m_pend++;
            if (m_pend >= TIMEOUT) m_err = 1'b1;
         end else begin
            m_pend = 0;
         end
      end
   endtask

   task automatic idle(input logic r, input logic req, input logic rdy, input logic br);
      step(r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, br, req, rdy);
   endtask

   // Monitor: outputs are combinational, so each cycle's response is sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ctrl", {25'd0, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                           exmem_stall, memwb_flush}, {25'd0, e.ctrl});
            check("timeout_err", {31'd0, mem_timeout_err}, {31'd0, e.err});
            check("stall_cycles", stall_cycles, e.sc);
            check("flush_events", flush_events, e.fe);
            cyc++;
         end
      end
   end

   initial begin
      int budget;
      // Reset state
      idle(1, 0, 0, 0);
      idle(1, 1, 0, 1);
      idle(0, 0, 0, 0);
      // Load-use on rs1, on rs2, and the x0 case
      step(0, 5'd5, 5'd1, 1, 0, 5'd5, 1, 0, 0, 0);
      idle(0, 0, 0, 0);
      step(0, 5'd2, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0);
      step(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
      step(0, 5'd5, 5'd1, 0, 0, 5'd5, 1, 0, 0, 0);
      // Branch overrides load-use
      step(0, 5'd5, 5'd1, 1, 0, 5'd5, 1, 1, 0, 0);
      idle(0, 0, 0, 0);
      // Memory wait of three cycles then ready
      repeat (3) idle(0, 1, 0, 0);
      idle(0, 1, 1, 0);
      idle(0, 0, 0, 0);
      // Zero-wait access and withdrawn request
      idle(0, 1, 1, 0);
      repeat (2) idle(0, 1, 0, 0);
      idle(0, 0, 0, 0);
      // Timeout: error sticks when ready rises, clears on reset edge
      repeat (TIMEOUT) idle(0, 1, 0, 0);
      repeat (2) idle(0, 1, 0, 0);
      idle(0, 1, 1, 1);
      idle(0, 0, 0, 0);
      idle(1, 0, 0, 0);
      idle(0, 0, 0, 0);
      // Reset mid-wait, then zero-wait access
      repeat (2) idle(0, 1, 0, 0);
      idle(1, 1, 0, 0);
      idle(0, 1, 1, 0);
      // Memory stall with a pending branch, then ready with branch still held
      repeat (2) idle(0, 1, 0, 1);
      idle(0, 1, 1, 1);
      idle(0, 0, 0, 0);
      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 39) == 0,
              AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), AW'($urandom_range(0, 3)),
              1'($urandom), $urandom_range(0, 5) == 0,
              1'($urandom), $urandom_range(0, 2) != 0);
      end
      budget = 0;
      while (sb.size() > 0 && budget < 10) begin
         @(negedge clk);
         budget++;
      end
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
